// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM state type, default tap masks and a single Fibonacci LFSR step
package lfsr_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;
  function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic [63:0] taps, input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    return ((s << 1) | 64'(^(s & taps))) & mask;
  endfunction
endpackage

// File: rtl/lfsr_step_unroll.sv
// lfsr_step_unroll: combinational chain of STEPS Fibonacci LFSR steps
//   state_in  : current LFSR state
//   state_out : state after STEPS shifts
module lfsr_step_unroll
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS16),
  parameter int STEPS = 1
)(
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out
);
  logic [WIDTH-1:0] chain [STEPS+1];
  assign chain[0] = state_in;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    assign chain[i+1] = WIDTH'(lfsr_step(64'(chain[i]), 64'(TAPS), WIDTH));
  end
  assign state_out = chain[STEPS];
endmodule

// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen: Fibonacci LFSR PRBS source with valid/ready output, seed load and zero-seed protection
//   enable                      : run request (level)
//   load_valid/load_seed/load_ready : seed load handshake, accepted only in IDLE
//   out_valid/out_ready/out_data    : PRBS word stream, out_data is the LFSR register
//   seed_err                    : sticky, a zero seed was replaced by SEED
//   LFSR_PERIOD_CNT_EN adds step_cnt (single steps since load/reset) and period_wrap (seed revisited)
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS16),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(16'h1001),
  parameter int STEPS = 1
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_seed,
  output logic             load_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             seed_err
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [WIDTH-1:0] step_cnt,
  output logic             period_wrap
`endif
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, stepped;
  logic seed_err_q, seed_err_d, load, accept;
  lfsr_step_unroll #(.WIDTH(WIDTH), .TAPS(TAPS), .STEPS(STEPS)) u_step (
    .state_in (lfsr_q),
    .state_out(stepped)
  );
  assign load   = state_q == IDLE && load_valid;
  assign accept = state_q != IDLE && out_ready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (!load_valid && enable) ? RUN : IDLE;
      RUN:     state_d = enable ? RUN : out_ready ? IDLE : DRAIN;
      DRAIN:   state_d = out_ready ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // a zero seed would lock the LFSR, so substitute SEED and flag it
  assign lfsr_d     = load ? (|load_seed ? load_seed : SEED) : accept ? stepped : lfsr_q;
  assign seed_err_d = seed_err_q | (load & ~|load_seed);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_err_q <= seed_err_d;
    end
  end
  assign load_ready = state_q == IDLE;
  assign out_valid  = state_q != IDLE;
  assign out_data   = lfsr_q;
  assign seed_err   = seed_err_q;
`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] seed_q, seed_d, step_cnt_q, step_cnt_d;
  logic period_wrap_q, period_wrap_d;
  always_comb begin
    seed_d        = load ? lfsr_d : seed_q;
    step_cnt_d    = load ? '0 : accept ? step_cnt_q + WIDTH'(STEPS) : step_cnt_q;
    period_wrap_d = accept && stepped == seed_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q        <= SEED;
      step_cnt_q    <= '0;
      period_wrap_q <= 1'b0;
    end else begin
      seed_q        <= seed_d;
      step_cnt_q    <= step_cnt_d;
      period_wrap_q <= period_wrap_d;
    end
  end
  assign step_cnt    = step_cnt_q;
  assign period_wrap = period_wrap_q;
`endif
endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb_lfsr_prbs_gen: scoreboard bench for lfsr_prbs_gen against an arithmetic PRBS model
module tb_lfsr_prbs_gen;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'h1001;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, load_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] load_seed = '0;
  logic load_ready, out_valid, seed_err;
  logic [15:0] out_data;
`ifdef LFSR_PERIOD_CNT_EN
  logic [15:0] step_cnt;
  logic period_wrap;
`endif
  lfsr_prbs_gen dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .load_valid(load_valid), .load_seed(load_seed), .load_ready(load_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .seed_err(seed_err)
`ifdef LFSR_PERIOD_CNT_EN
    , .step_cnt(step_cnt), .period_wrap(period_wrap)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_q[$], seen_q[$];
  int m_mode = 0, cur_mode = 0;
  logic [15:0] m_lfsr = SEED, m_cnt = '0, cur_cnt = '0;
  logic m_err = 1'b0, cur_err = 1'b0;
  bit active = 0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [15:0] prev_d = '0;
  int acc_cnt = 0, wrap_acc = -1;
  bit wrap_seen = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    int v;
    v = (int'(s) * 2) % 65536 + $countones(s & TAPS) % 2;
    return 16'(v);
  endfunction
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
      acc_cnt = 0;
      wrap_seen = 0;
      wrap_acc = -1;
    end else if (active) begin
      check("out_valid", out_valid, cur_mode != 0);
      check("load_ready", load_ready, cur_mode == 0);
      check("seed_err", seed_err, cur_err);
      if (prev_v && !prev_r) check("hold_data", out_data, prev_d);
`ifdef LFSR_PERIOD_CNT_EN
      check("step_cnt", step_cnt, cur_cnt);
      if (period_wrap && !wrap_seen) begin
        wrap_seen = 1;
        wrap_acc = acc_cnt;
      end
`endif
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          check("data", out_data, exp_q.pop_front());
          seen_q.push_back(out_data);
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
    end
  end
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_data", out_data, SEED);
    check("rst_valid", out_valid, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_seed_err", seed_err, 1'b0);
`ifdef LFSR_PERIOD_CNT_EN
    check("rst_step_cnt", step_cnt, 0);
`endif
    m_mode = 0; m_lfsr = SEED; m_err = 1'b0; m_cnt = '0;
    cur_mode = 0; cur_err = 1'b0; cur_cnt = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  task automatic cycle(input logic en, input logic rdy, input logic lv, input logic [15:0] sd);
    enable = en; out_ready = rdy; load_valid = lv; load_seed = sd;
    cur_mode = m_mode; cur_err = m_err; cur_cnt = m_cnt;
    if (m_mode == 0) begin
      if (lv) begin
        m_lfsr = (sd == 0) ? SEED : sd;
        m_err = m_err | (sd == 0);
        m_cnt = '0;
      end else if (en) m_mode = 1;
    end else begin
      if (rdy) begin
        exp_q.push_back(m_lfsr);
        m_lfsr = ref_step(m_lfsr);
        m_cnt = m_cnt + 16'd1;
      end
      if (m_mode == 2) m_mode = rdy ? 0 : 2;
      else if (!en) m_mode = rdy ? 0 : 2;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] golden [5];
    golden[0] = 16'h1001; golden[1] = 16'h2003; golden[2] = 16'h4007;
    golden[3] = 16'h800E; golden[4] = 16'h001D;
    @(posedge clk);
    #1;
    do_reset();
    active = 1;
    seen_q.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check("seq_len", seen_q.size(), 5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++) check("golden_seq", seen_q[i], golden[i]);
    do_reset();
    seen_q.delete();
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("stall_data", out_data, 16'h2003);
      check("stall_valid", out_valid, 1'b1);
    end
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("stall_seq_len", seen_q.size(), 3);
    if (seen_q.size() == 3) check("after_stall", seen_q[2], 16'h4007);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("drain_load_ready", load_ready, 1'b0);
    check("drain_valid", out_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("idle_valid", out_valid, 1'b0);
    check("idle_load_ready", load_ready, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    check("zero_seed_data", out_data, 16'h1001);
    check("zero_seed_err", seed_err, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 16'hACE1);
    check("prio_data", out_data, 16'hACE1);
    check("prio_valid", out_valid, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("prio_run_valid", out_valid, 1'b1);
    check("prio_first_word", out_data, 16'hACE1);
    check("err_sticky", seed_err, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom));
    end
`ifdef LFSR_PERIOD_CNT_EN
    do_reset();
    for (int i = 0; i < 70000 && !wrap_seen; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check("wrap_seen", wrap_seen, 1'b1);
    check("wrap_steps", wrap_acc, 65535);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    do_reset();
`endif
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
